// File: rtl/pll_lock_supervisor.sv
// Qualifies the asynchronous rPLL LOCK on the reference clock, pulses the PLL reset and retries on lock timeout.
// Releases the generated-clock system reset only after lock is stable; keeps saturating loss/retry counts for debug.
module pll_lock_supervisor #(
  parameter int PLL_RST_CYCLES      = 27,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 270000,
  parameter int CNT_W               = 8
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic             in_pll_lock,
  input  logic             in_clear_counts,
  output logic             out_pll_reset,
  output logic             out_sys_reset,
  output logic             out_locked,
  output logic [CNT_W-1:0] out_loss_count,
  output logic [CNT_W-1:0] out_retry_count
);

  localparam int RW = $clog2(PLL_RST_CYCLES);
  localparam int SW = $clog2(LOCK_STABLE_CYCLES);
  localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES);

  localparam logic [RW-1:0]    RST_LAST = RW'(PLL_RST_CYCLES - 1);
  localparam logic [SW-1:0]    STB_LAST = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TW-1:0]    TO_LAST  = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_QUALIFY,
    S_RUN
  } state_t;

  state_t           state_q, state_d;
  logic             lock_m_q, lock_s_q;
  logic [RW-1:0]    rst_cnt_q, rst_cnt_d;
  logic [SW-1:0]    stb_q, stb_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [CNT_W-1:0] loss_q, loss_d, retry_q, retry_d;
  logic             pll_reset_q, sys_reset_q, locked_q;
  logic             loss_inc, retry_inc;

  // stb_q holds the number of stable cycles already seen, so the cycle with stb_q == STB_LAST is the last one.
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = '0;
    stb_d     = '0;
    tmr_d     = tmr_q;
    loss_inc  = 1'b0;
    retry_inc = 1'b0;
    case (state_q)
      S_PLL_RST: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d = S_WAIT_LOCK;
          tmr_d   = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        tmr_d = tmr_q + 1'b1;
        if (tmr_q == TO_LAST) begin
          state_d   = S_PLL_RST;
          retry_inc = 1'b1;
        end else if (lock_s_q) begin
          state_d = S_QUALIFY;
          stb_d   = SW'(1);
        end
      end
      S_QUALIFY: begin
        tmr_d = tmr_q + 1'b1;
        if (tmr_q == TO_LAST) begin
          state_d   = S_PLL_RST;
          retry_inc = 1'b1;
        end else if (!lock_s_q) begin
          state_d = S_WAIT_LOCK;
        end else if (stb_q == STB_LAST) begin
          state_d = S_RUN;
        end else begin
          stb_d = stb_q + 1'b1;
        end
      end
      S_RUN: begin
        if (!lock_s_q) begin
          state_d  = S_PLL_RST;
          loss_inc = 1'b1;
        end
      end
      default: state_d = S_PLL_RST;
    endcase

    // A clear always wins over an increment in the same cycle.
    if (in_clear_counts) begin
      loss_d  = '0;
      retry_d = '0;
    end else begin
      loss_d  = (loss_inc && loss_q != CNT_SAT) ? loss_q + 1'b1 : loss_q;
      retry_d = (retry_inc && retry_q != CNT_SAT) ? retry_q + 1'b1 : retry_q;
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      lock_m_q    <= 1'b0;
      lock_s_q    <= 1'b0;
      state_q     <= S_PLL_RST;
      rst_cnt_q   <= '0;
      stb_q       <= '0;
      tmr_q       <= '0;
      loss_q      <= '0;
      retry_q     <= '0;
      pll_reset_q <= 1'b1;
      sys_reset_q <= 1'b1;
      locked_q    <= 1'b0;
    end else begin
      lock_m_q    <= in_pll_lock;
      lock_s_q    <= lock_m_q;
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      stb_q       <= stb_d;
      tmr_q       <= tmr_d;
      loss_q      <= loss_d;
      retry_q     <= retry_d;
      pll_reset_q <= (state_d == S_PLL_RST);
      sys_reset_q <= (state_d != S_RUN);
      locked_q    <= (state_d == S_RUN);
    end
  end

  assign out_pll_reset   = pll_reset_q;
  assign out_sys_reset   = sys_reset_q;
  assign out_locked      = locked_q;
  assign out_loss_count  = loss_q;
  assign out_retry_count = retry_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with short parameters (reset 4, stable 8, timeout 64, 4-bit counters).
module tb_pll_lock_supervisor;

  logic       clk;
  logic       rst;
  logic       lock;
  logic       clr;
  logic       pll_reset;
  logic       sys_reset;
  logic       locked;
  logic [3:0] loss_cnt;
  logic [3:0] retry_cnt;

  int checks = 0;
  int errors = 0;

  pll_lock_supervisor #(
    .PLL_RST_CYCLES(4),
    .LOCK_STABLE_CYCLES(8),
    .LOCK_TIMEOUT_CYCLES(64),
    .CNT_W(4)
  ) dut (
    .in_clk(clk),
    .in_rst(rst),
    .in_pll_lock(lock),
    .in_clear_counts(clr),
    .out_pll_reset(pll_reset),
    .out_sys_reset(sys_reset),
    .out_locked(locked),
    .out_loss_count(loss_cnt),
    .out_retry_count(retry_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves in_rst released just after an edge, so the next posedge is edge 1 of the sequence.
  task automatic do_reset();
    rst  = 1'b1;
    lock = 1'b0;
    clr  = 1'b0;
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic wait_locked(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      step();
      if (locked === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    lock = 1'b0;
    clr  = 1'b0;
    repeat (2) step();
    checks++;
    if ({pll_reset, sys_reset, locked, loss_cnt, retry_cnt} !== {1'b1, 1'b1, 1'b0, 4'd0, 4'd0}) begin
      errors++;
      $display("FAIL reset_values: got pll=%b sys=%b locked=%b loss=%0d retry=%0d expected 1 1 0 0 0",
               pll_reset, sys_reset, locked, loss_cnt, retry_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_timeout_retry();
    logic       exp_pll;
    logic [3:0] exp_retry;
    do_reset();
    for (int n = 1; n <= 68 * 17; n++) begin
      step();
      exp_pll   = (n % 68) < 4;
      exp_retry = (n / 68 > 15) ? 4'd15 : 4'(n / 68);
      checks++;
      if (pll_reset !== exp_pll) begin
        errors++;
        $display("FAIL retry_pll_reset edge %0d: got %b expected %b", n, pll_reset, exp_pll);
      end
      checks++;
      if (retry_cnt !== exp_retry) begin
        errors++;
        $display("FAIL retry_count edge %0d: got %0d expected %0d", n, retry_cnt, exp_retry);
      end
      checks++;
      if (sys_reset !== 1'b1) begin
        errors++;
        $display("FAIL retry_sys_reset edge %0d: got %b expected 1", n, sys_reset);
      end
    end
  endtask

  task automatic test_lock_release();
    do_reset();
    repeat (4) step();
    checks++;
    if (pll_reset !== 1'b0) begin
      errors++;
      $display("FAIL release_pll_fall: got %b expected 0", pll_reset);
    end
    repeat (10) step();
    lock = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      checks++;
      if (locked !== (i == 10) || sys_reset !== (i != 10)) begin
        errors++;
        $display("FAIL release_latency edge %0d: got locked=%b sys=%b expected locked=%b sys=%b",
                 i, locked, sys_reset, (i == 10), (i != 10));
      end
    end
    checks++;
    if (retry_cnt !== 4'd0) begin
      errors++;
      $display("FAIL release_retry: got %0d expected 0", retry_cnt);
    end
  endtask

  task automatic test_glitch_qualify();
    do_reset();
    repeat (4) step();
    lock = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      checks++;
      if (locked !== 1'b0) begin
        errors++;
        $display("FAIL glitch_first_high edge %0d: got %b expected 0", i, locked);
      end
    end
    lock = 1'b0;
    step();
    lock = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      checks++;
      if (locked !== (i == 10)) begin
        errors++;
        $display("FAIL glitch_release edge %0d: got %b expected %b", i, locked, (i == 10));
      end
    end
  endtask

  // Runs straight after the glitch test, which leaves the block in RUN.
  task automatic test_loss();
    lock = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      step();
      checks++;
      if (locked !== (i < 3) || sys_reset !== (i >= 3)) begin
        errors++;
        $display("FAIL loss_latency edge %0d: got locked=%b sys=%b expected locked=%b sys=%b",
                 i, locked, sys_reset, (i < 3), (i >= 3));
      end
      checks++;
      if (pll_reset !== (i >= 3 && i <= 6)) begin
        errors++;
        $display("FAIL loss_pll_pulse edge %0d: got %b expected %b", i, pll_reset, (i >= 3 && i <= 6));
      end
      checks++;
      if (loss_cnt !== ((i >= 3) ? 4'd1 : 4'd0)) begin
        errors++;
        $display("FAIL loss_count edge %0d: got %0d expected %0d", i, loss_cnt, (i >= 3) ? 1 : 0);
      end
    end
  endtask

  task automatic test_chatter();
    do_reset();
    repeat (4) step();
    for (int n = 5; n <= 104; n++) begin
      lock = ((n - 5) % 5) != 4;
      step();
      checks++;
      if (locked !== 1'b0) begin
        errors++;
        $display("FAIL chatter_locked edge %0d: got %b expected 0", n, locked);
      end
      checks++;
      if (pll_reset !== (n >= 68 && n <= 71)) begin
        errors++;
        $display("FAIL chatter_pll_reset edge %0d: got %b expected %b", n, pll_reset, (n >= 68 && n <= 71));
      end
      checks++;
      if (retry_cnt !== ((n >= 68) ? 4'd1 : 4'd0)) begin
        errors++;
        $display("FAIL chatter_retry edge %0d: got %0d expected %0d", n, retry_cnt, (n >= 68) ? 1 : 0);
      end
    end
    lock = 1'b0;
  endtask

  task automatic test_clear_and_async_reset();
    bit ok;
    do_reset();
    lock = 1'b1;
    wait_locked(40, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL clear_first_lock: got no lock within 40 cycles, expected lock");
    end
    lock = 1'b0;
    repeat (3) step();
    checks++;
    if (loss_cnt !== 4'd1) begin
      errors++;
      $display("FAIL clear_pre_loss: got %0d expected 1", loss_cnt);
    end
    lock = 1'b1;
    wait_locked(40, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL clear_second_lock: got no lock within 40 cycles, expected lock");
    end
    lock = 1'b0;
    repeat (2) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    checks++;
    if (loss_cnt !== 4'd0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL clear_wins: got loss=%0d locked=%b expected loss=0 locked=0", loss_cnt, locked);
    end
    lock = 1'b1;
    wait_locked(40, ok);
    lock = 1'b0;
    repeat (3) step();
    lock = 1'b1;
    wait_locked(40, ok);
    checks++;
    if (!ok || loss_cnt !== 4'd1) begin
      errors++;
      $display("FAIL async_pre_state: got locked=%b loss=%0d expected locked=1 loss=1", ok, loss_cnt);
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({pll_reset, sys_reset, locked, loss_cnt, retry_cnt} !== {1'b1, 1'b1, 1'b0, 4'd0, 4'd0}) begin
      errors++;
      $display("FAIL async_reset: got pll=%b sys=%b locked=%b loss=%0d retry=%0d expected 1 1 0 0 0",
               pll_reset, sys_reset, locked, loss_cnt, retry_cnt);
    end
    step();
    rst  = 1'b0;
    lock = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    lock = 1'b0;
    clr  = 1'b0;
    test_reset();
    test_timeout_retry();
    test_lock_release();
    test_glitch_qualify();
    test_loss();
    test_chatter();
    test_clear_and_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
